// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pckg
//  Description : Shared encodings and types for the ID-stage hazard scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_pckg;

    localparam logic [1:0] c_CHK_NONE    = 2'b00;
    localparam logic [1:0] c_CHK_RS1     = 2'b01;
    localparam logic [1:0] c_CHK_RS2     = 2'b10;
    localparam logic [1:0] c_CHK_RS1_RS2 = 2'b11;

    // Countdown storage is sized for the widest supported latency field.
    localparam int c_LAT_W_MAX = 8;

    typedef struct packed {
        logic                   busy;
        logic                   is_var;
        logic [c_LAT_W_MAX-1:0] cnt;
    } sb_entry_t;

    typedef struct packed {
        logic raw_rs1;
        logic raw_rs2;
        logic waw;
    } hazard_cause_t;

    function automatic logic chk_rs1(input logic [1:0] sel);
        return (sel == c_CHK_RS1) || (sel == c_CHK_RS1_RS2);
    endfunction

    function automatic logic chk_rs2(input logic [1:0] sel);
        return (sel == c_CHK_RS2) || (sel == c_CHK_RS1_RS2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard_if
//  Description : ID-stage, issue and writeback signals of the hazard scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hazard_scoreboard_if #(
    parameter int NUM_REGS = 32,
    parameter int ALEN     = 5,
    parameter int LAT_W    = 3,
    parameter int CNT_W    = 16
);
    logic [ALEN-1:0]     i_rs1;
    logic [ALEN-1:0]     i_rs2;
    logic [1:0]          i_check_regs;
    logic                i_has_rd;
    logic [ALEN-1:0]     i_rd;
    logic                i_is_valid;
    logic                i_pipeline_stalled;
    logic                i_issue;
    logic                i_issue_var;
    logic [LAT_W-1:0]    i_issue_lat;
    logic                i_wb_valid;
    logic [ALEN-1:0]     i_wb_rd;
    logic                o_stall;
    logic                o_raw_rs1;
    logic                o_raw_rs2;
    logic                o_waw;
    logic [NUM_REGS-1:0] o_busy;
    logic [CNT_W-1:0]    o_stall_cycles;

    modport master (
        output i_rs1, i_rs2, i_check_regs, i_has_rd, i_rd, i_is_valid,
               i_pipeline_stalled, i_issue, i_issue_var, i_issue_lat,
               i_wb_valid, i_wb_rd,
        input  o_stall, o_raw_rs1, o_raw_rs2, o_waw, o_busy, o_stall_cycles
    );

    modport slave (
        input  i_rs1, i_rs2, i_check_regs, i_has_rd, i_rd, i_is_valid,
               i_pipeline_stalled, i_issue, i_issue_var, i_issue_lat,
               i_wb_valid, i_wb_rd,
        output o_stall, o_raw_rs1, o_raw_rs2, o_waw, o_busy, o_stall_cycles
    );
endinterface
`default_nettype wire

// File: rtl/hazard_scoreboard_sb_entry.sv
`default_nettype none
// ============================================================================
//  Module      : sb_entry
//  Description : One register's busy/var flags and fixed-latency countdown.
//  Revision    : 1.0 - initial release
// ============================================================================
module sb_entry
    import hazard_pckg::*;
#(
    parameter int LAT_W = 3
) (
    input  wire logic             i_clk,
    input  wire logic             i_rst,
    input  wire logic             i_issue,
    input  wire logic             i_issue_var,
    input  wire logic [LAT_W-1:0] i_issue_lat,
    input  wire logic             i_wb_clr,
    input  wire logic             i_freeze,
    output logic                  o_busy,
    output logic                  o_var
);

    sb_entry_t r_entry;

    // Issue has priority so a same-cycle clear of the old producer reloads the entry.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_entry <= '0;
        end else if (i_issue) begin
            r_entry.busy   <= 1'b1;
            r_entry.is_var <= i_issue_var;
            r_entry.cnt    <= i_issue_var ? '0 : c_LAT_W_MAX'(i_issue_lat);
        end else if (i_wb_clr && r_entry.busy && r_entry.is_var) begin
            r_entry <= '0;
        end else if (r_entry.busy && !r_entry.is_var && !i_freeze) begin
            r_entry.cnt <= r_entry.cnt - c_LAT_W_MAX'(1);
            if (r_entry.cnt <= c_LAT_W_MAX'(1)) begin
                r_entry.busy <= 1'b0;
            end
        end
    end

    assign o_busy = r_entry.busy;
    assign o_var  = r_entry.is_var;

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : Per-register scoreboard raising ID-stage RAW/WAW stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import hazard_pckg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter int ALEN      = 5,
    parameter int LAT_W     = 3,
    parameter int CNT_W     = 16,
    parameter int BYPASS_WB = 1
) (
    input wire logic           i_clk,
    input wire logic           i_rst,
    hazard_scoreboard_if.slave sb_if
);

    localparam int c_SPAN = 2**ALEN;

    logic [c_SPAN-1:0] w_busy;
    logic [c_SPAN-1:0] w_var;
    logic [c_SPAN-1:0] w_bypass;
    logic [c_SPAN-1:0] w_eff_busy;
    logic              w_issue_ok;
    logic              w_stall;
    hazard_cause_t     w_cause;
    logic [CNT_W-1:0]  r_stall_cycles;

    assign w_issue_ok = sb_if.i_issue && sb_if.i_has_rd && (sb_if.i_rd != '0) && !w_stall &&
                        (sb_if.i_issue_var || (sb_if.i_issue_lat != '0));

    // Slot 0 and addresses beyond NUM_REGS have no entry and always read idle.
    for (genvar r = 0; r < c_SPAN; r++) begin : g_slot
        if (r > 0 && r < NUM_REGS) begin : g_entry
            sb_entry #(.LAT_W(LAT_W)) u_entry (
                .i_clk       (i_clk),
                .i_rst       (i_rst),
                .i_issue     (w_issue_ok && (sb_if.i_rd == ALEN'(r))),
                .i_issue_var (sb_if.i_issue_var),
                .i_issue_lat (sb_if.i_issue_lat),
                .i_wb_clr    (sb_if.i_wb_valid && (sb_if.i_wb_rd == ALEN'(r))),
                .i_freeze    (sb_if.i_pipeline_stalled),
                .o_busy      (w_busy[r]),
                .o_var       (w_var[r])
            );
        end else begin : g_none
            assign w_busy[r] = 1'b0;
            assign w_var[r]  = 1'b0;
        end
    end

    assign w_bypass   = ((BYPASS_WB != 0) && sb_if.i_wb_valid) ?
                        (w_var & (c_SPAN'(1) << sb_if.i_wb_rd)) : '0;
    assign w_eff_busy = w_busy & ~w_bypass;

    always_comb begin
        w_cause = '0;
        w_stall = 1'b0;
        if (!sb_if.i_is_valid && sb_if.i_pipeline_stalled) begin
            w_stall = 1'b1;
        end else if (sb_if.i_is_valid) begin
            w_cause.raw_rs1 = chk_rs1(sb_if.i_check_regs) && (sb_if.i_rs1 != '0) && w_eff_busy[sb_if.i_rs1];
            w_cause.raw_rs2 = chk_rs2(sb_if.i_check_regs) && (sb_if.i_rs2 != '0) && w_eff_busy[sb_if.i_rs2];
            w_cause.waw     = sb_if.i_has_rd && (sb_if.i_rd != '0) && w_eff_busy[sb_if.i_rd];
            w_stall         = |w_cause;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != {CNT_W{1'b1}})) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && sb_if.i_issue) begin
            assert (!w_stall);
        end
    end

    assign sb_if.o_stall        = w_stall;
    assign sb_if.o_raw_rs1      = w_cause.raw_rs1;
    assign sb_if.o_raw_rs2      = w_cause.raw_rs2;
    assign sb_if.o_waw          = w_cause.waw;
    assign sb_if.o_busy         = w_busy[NUM_REGS-1:0];
    assign sb_if.o_stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_scoreboard
//  Description : Directed and random checks of hazard_scoreboard against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    localparam int NREGS = 32;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam bit BYP   = 1'b1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    bit m_busy [NREGS];
    bit m_var  [NREGS];
    int m_rem  [NREGS];
    int m_cnt;

    hazard_scoreboard_if #(.NUM_REGS(NREGS), .ALEN(5), .LAT_W(3), .CNT_W(CNT_W)) sb_if ();

    hazard_scoreboard #(.NUM_REGS(NREGS), .ALEN(5), .LAT_W(3), .CNT_W(CNT_W), .BYPASS_WB(1)) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .sb_if (sb_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic bit m_eff(input int x);
        if (x == 0 || x >= NREGS) return 1'b0;
        if (BYP && sb_if.i_wb_valid && int'(sb_if.i_wb_rd) == x && m_var[x]) return 1'b0;
        return m_busy[x];
    endfunction

    task automatic model_eval(output bit st, output bit r1, output bit r2, output bit ww);
        int c = int'(sb_if.i_check_regs);
        st = 0; r1 = 0; r2 = 0; ww = 0;
        if (!sb_if.i_is_valid && sb_if.i_pipeline_stalled) begin
            st = 1;
        end else if (sb_if.i_is_valid) begin
            r1 = (c == 1 || c == 3) && sb_if.i_rs1 != 0 && m_eff(int'(sb_if.i_rs1));
            r2 = (c == 2 || c == 3) && sb_if.i_rs2 != 0 && m_eff(int'(sb_if.i_rs2));
            ww = sb_if.i_has_rd && sb_if.i_rd != 0 && m_eff(int'(sb_if.i_rd));
            st = r1 | r2 | ww;
        end
    endtask

    function automatic logic [31:0] m_busy_vec();
        logic [31:0] v = '0;
        for (int r = 0; r < NREGS; r++) v[r] = m_busy[r];
        return v;
    endfunction

    task automatic model_next(input bit st);
        bit iss = sb_if.i_issue && sb_if.i_has_rd && sb_if.i_rd != 0 && !st &&
                  (sb_if.i_issue_var || sb_if.i_issue_lat != 0);
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin m_busy[r] = 0; m_var[r] = 0; m_rem[r] = 0; end
            m_cnt = 0;
            return;
        end
        for (int r = 1; r < NREGS; r++) begin
            if (iss && int'(sb_if.i_rd) == r) begin
                m_busy[r] = 1; m_var[r] = sb_if.i_issue_var;
                m_rem[r]  = sb_if.i_issue_var ? 0 : int'(sb_if.i_issue_lat);
            end else if (sb_if.i_wb_valid && int'(sb_if.i_wb_rd) == r && m_busy[r] && m_var[r]) begin
                m_busy[r] = 0; m_var[r] = 0;
            end else if (m_busy[r] && !m_var[r] && !sb_if.i_pipeline_stalled) begin
                m_rem[r]--;
                if (m_rem[r] == 0) m_busy[r] = 0;
            end
        end
        if (st && m_cnt < CMAX) m_cnt++;
    endtask

    task automatic step();
        bit st, r1, r2, ww;
        @(negedge clk);
        model_eval(st, r1, r2, ww);
        chk("busy", 32'(sb_if.o_busy), m_busy_vec());
        chk("stall", 32'(sb_if.o_stall), 32'(st));
        chk("cause", {29'd0, sb_if.o_raw_rs1, sb_if.o_raw_rs2, sb_if.o_waw}, {29'd0, r1, r2, ww});
        chk("stall_cycles", 32'(sb_if.o_stall_cycles), 32'(m_cnt));
        model_next(st);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sb_if.i_rs1 = 0; sb_if.i_rs2 = 0; sb_if.i_check_regs = 2'b00;
        sb_if.i_has_rd = 0; sb_if.i_rd = 0; sb_if.i_is_valid = 0;
        sb_if.i_pipeline_stalled = 0; sb_if.i_issue = 0; sb_if.i_issue_var = 0;
        sb_if.i_issue_lat = 0; sb_if.i_wb_valid = 0; sb_if.i_wb_rd = 0;
    endtask

    task automatic issue(input int rd, input bit is_var, input int lat);
        idle();
        sb_if.i_is_valid = 1; sb_if.i_has_rd = 1; sb_if.i_rd = 5'(rd);
        sb_if.i_issue = 1; sb_if.i_issue_var = is_var; sb_if.i_issue_lat = 3'(lat);
    endtask

    initial begin
        bit st, r1, r2, ww;
        for (int r = 0; r < NREGS; r++) begin m_busy[r] = 0; m_var[r] = 0; m_rem[r] = 0; end
        m_cnt = 0;
        idle();
        rst = 1;
        @(posedge clk); #1;
        model_next(1'b0);
        step();
        rst = 0;
        step();
        chk("idle_busy", 32'(sb_if.o_busy), 32'd0);
        chk("idle_cnt", 32'(sb_if.o_stall_cycles), 32'd0);

        issue(5, 0, 0); step();
        idle(); step();
        chk("lat0_busy", 32'(sb_if.o_busy), 32'd0);

        issue(3, 0, 2); step();
        idle(); sb_if.i_is_valid = 1; sb_if.i_check_regs = 2'b01; sb_if.i_rs1 = 3;
        repeat (3) step();
        chk("fixed_cnt", 32'(sb_if.o_stall_cycles), 32'd2);

        issue(7, 0, 3); step();
        idle(); sb_if.i_is_valid = 1; sb_if.i_pipeline_stalled = 1;
        repeat (4) step();
        sb_if.i_is_valid = 0; step();
        chk("frz_hold", 32'(sb_if.o_busy[7]), 32'd1);
        idle(); repeat (2) step();
        chk("frz_rel2", 32'(sb_if.o_busy[7]), 32'd1);
        step();
        chk("frz_rel3", 32'(sb_if.o_busy[7]), 32'd0);

        issue(10, 1, 0); step();
        idle(); sb_if.i_is_valid = 1; sb_if.i_check_regs = 2'b10; sb_if.i_rs2 = 10;
        repeat (5) step();
        sb_if.i_wb_valid = 1; sb_if.i_wb_rd = 10;
        step();
        chk("var_clr", 32'(sb_if.o_busy[10]), 32'd0);

        issue(4, 1, 0); step();
        idle(); sb_if.i_is_valid = 1; sb_if.i_has_rd = 1; sb_if.i_rd = 4;
        step();
        issue(4, 1, 0); sb_if.i_wb_valid = 1; sb_if.i_wb_rd = 4;
        step();
        chk("collide", 32'(sb_if.o_busy[4]), 32'd1);

        idle(); sb_if.i_is_valid = 1; sb_if.i_check_regs = 2'b01; sb_if.i_rs1 = 4;
        repeat (20) step();
        chk("saturate", 32'(sb_if.o_stall_cycles), 32'(CMAX));

        rst = 1; step(); rst = 0;
        chk("rst_busy", 32'(sb_if.o_busy), 32'd0);
        chk("rst_cnt", 32'(sb_if.o_stall_cycles), 32'd0);

        for (int i = 0; i < 600; i++) begin
            sb_if.i_rs1              = 5'($urandom_range(0, 7));
            sb_if.i_rs2              = 5'($urandom_range(0, 7));
            sb_if.i_rd               = 5'($urandom_range(0, 7));
            sb_if.i_wb_rd            = 5'($urandom_range(0, 7));
            sb_if.i_check_regs       = 2'($urandom_range(0, 3));
            sb_if.i_has_rd           = 1'($urandom_range(0, 1));
            sb_if.i_is_valid         = ($urandom_range(0, 9) < 8);
            sb_if.i_pipeline_stalled = ($urandom_range(0, 9) < 2);
            sb_if.i_issue_var        = ($urandom_range(0, 9) < 3);
            sb_if.i_issue_lat        = 3'($urandom_range(0, 7));
            sb_if.i_wb_valid         = ($urandom_range(0, 9) < 3);
            rst                      = ($urandom_range(0, 99) == 0);
            model_eval(st, r1, r2, ww);
            sb_if.i_issue = !st && !rst && ($urandom_range(0, 1) == 1);
            step();
        end
        rst = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
